// File: rtl/ibex_pkg.sv
// Shared instruction-side definitions: identifiers for the fetch masters
// that share the instruction memory port.
package ibex_pkg;

    typedef logic instr_mst_id_t;

    localparam instr_mst_id_t INSTR_MST_PREFETCH = 1'b0;
    localparam instr_mst_id_t INSTR_MST_AUX      = 1'b1;

endpackage

// File: rtl/ibex_instr_id_fifo.sv
// In-order FIFO of master IDs, one entry per accepted-but-unanswered
// instruction fetch, so responses can be routed back to their issuer.
module ibex_instr_id_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_push,
    input  instr_mst_id_t i_id,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output instr_mst_id_t o_head
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    instr_mst_id_t   r_mem [Depth];
    logic [PtrW-1:0] r_wrPtr;
    logic [PtrW-1:0] r_rdPtr;
    logic [CntW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == FullCnt);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rdPtr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= INSTR_MST_PREFETCH;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= i_id;
        end
    end

    // Pointers wrap at Depth, which need not be a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == LastPtr) ? '0 : r_wrPtr + PtrW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == LastPtr) ? '0 : r_rdPtr + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin arbiter sharing the instruction memory port between the
// prefetch buffer and an auxiliary fetcher, with in-order response routing.
module ibex_instr_bus_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,

    output logic [31:0] m_rdata_o,
    output logic        m_err_o,

    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,

    output logic        busy_o,
    output logic        protocol_err_o
);

    logic          r_lock;
    instr_mst_id_t r_lockId;
    instr_mst_id_t r_rr;

    instr_mst_id_t w_sel;
    logic          w_selReq;
    logic [31:0]   w_selAddr;
    logic          w_busReq;
    logic          w_accept;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    instr_mst_id_t w_head;

    // A locked request keeps its master until granted or withdrawn.
    always_comb begin
        w_sel = r_rr;
        if (r_lock) begin
            w_sel = r_lockId;
        end else if (m0_req_i && !m1_req_i) begin
            w_sel = INSTR_MST_PREFETCH;
        end else if (m1_req_i && !m0_req_i) begin
            w_sel = INSTR_MST_AUX;
        end
    end

    assign w_selReq  = (w_sel == INSTR_MST_AUX) ? m1_req_i  : m0_req_i;
    assign w_selAddr = (w_sel == INSTR_MST_AUX) ? m1_addr_i : m0_addr_i;

    // Outputs are forced low while reset is held, even if masters request.
    assign w_busReq = rst_ni & w_selReq & ~w_full;
    assign w_accept = w_busReq & bus_gnt_i;
    assign w_pop    = rst_ni & bus_rvalid_i & ~w_empty;

    assign bus_req_o  = w_busReq;
    assign bus_addr_o = (rst_ni && w_selReq) ? w_selAddr : 32'h0;

    assign m0_gnt_o = w_accept & (w_sel == INSTR_MST_PREFETCH);
    assign m1_gnt_o = w_accept & (w_sel == INSTR_MST_AUX);

    assign m0_rvalid_o = w_pop & (w_head == INSTR_MST_PREFETCH);
    assign m1_rvalid_o = w_pop & (w_head == INSTR_MST_AUX);
    assign m_rdata_o   = rst_ni ? bus_rdata_i : 32'h0;
    assign m_err_o     = rst_ni & bus_err_i;

    assign busy_o         = rst_ni & (~w_empty | w_busReq);
    assign protocol_err_o = rst_ni & bus_rvalid_i & w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock   <= 1'b0;
            r_lockId <= INSTR_MST_PREFETCH;
        end else if (w_busReq && !bus_gnt_i) begin
            r_lock   <= 1'b1;
            r_lockId <= w_sel;
        end else if (w_accept) begin
            r_lock <= 1'b0;
        end else if (r_lock && !w_selReq) begin
            r_lock <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= INSTR_MST_PREFETCH;
        end else if (w_accept) begin
            r_rr <= ~w_sel;
        end
    end

    ibex_instr_id_fifo #(
        .Depth(MaxOutstanding)
    ) u_idFifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_push (w_accept),
        .i_id   (w_sel),
        .i_pop  (w_pop),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_head (w_head)
    );

endmodule
